trng_postproc: RTL and testbench
================================

# trng_postproc

Post-processing stage directly downstream of the ring-oscillator combiner. Samples the combined raw bit every clock and removes bias with a von Neumann extractor. Packs debiased bits into words delivered over a valid/ready handshake. Runs a repetition-count health test on the raw stream and latches a sticky failure that blocks all further output until reset.

## Interface
Parameters:
- `WORD_WIDTH`, default 8: debiased bits per output word (≥2).
- `REP_LIMIT`, default 32: consecutive identical raw samples that trip the health test (≥2).

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  sampling enable; matches the combiner's enable.
- `raw_bit`  in  1  combiner output, already registered in the `clock` domain.
- `word_data`  out  WORD_WIDTH  packed random word.
- `word_valid`  out  1  `word_data` holds an unconsumed word.
- `word_ready`  in  1  consumer accepts the word this cycle.
- `health_fail`  out  1  sticky repetition-count failure.
- `overflow`  out  1  sticky flag: at least one debiased bit was dropped.

## Operation
- Reset values: all outputs 0. Pair phase = first. Bit count = 0. Repetition counter = 0, with the last-sample register marked invalid.
- Sampling happens only when `enable`=1 and `health_fail`=0. One sample per rising edge.
- `enable`=0 in any cycle:
  - discard any half pair (phase returns to first);
  - clear the repetition counter and invalidate the last-sample register;
  - leave the shift register, the output slot and both sticky flags untouched.
- Von Neumann extractor: samples are paired (first, second).
  - 01 → debiased bit 0.
  - 10 → debiased bit 1.
  - 00 or 11 → no bit.
- Packing: each debiased bit is shifted in at the LSB and shifts left, so the first bit of a word ends at `word_data[WORD_WIDTH-1]`.
- Output slot is a single register, free when `word_valid`=0 or `word_ready`=1.
- When a debiased bit completes a word (count reaches WORD_WIDTH):
  - slot free on the same edge: load the word into `word_data`, set `word_valid`=1, reset count to 0;
  - slot not free: keep the word in the shift register (count = WORD_WIDTH).
- A held full word transfers on the first edge where the slot is free. Debiased bits produced while the word is held are dropped, and each drop sets `overflow`.
- Handshake: a transfer happens when `word_valid` & `word_ready`.
  - `word_data` must stay stable while `word_valid`=1 and `word_ready`=0.
  - If no new word is loaded on the transfer edge, `word_valid` falls.
- Repetition test:
  - counter = length of the current run of identical raw samples, including the current sample;
  - a sample that differs from the last one restarts the count at 1;
  - on the edge where the counter reaches REP_LIMIT, set `health_fail`.
- Once `health_fail`=1:
  - `word_valid` is forced to 0 on the same edge (a pending word is discarded);
  - the shift register and count are cleared and sampling stops;
  - only `reset` clears it.
- Counter width is `$clog2(REP_LIMIT+1)`; the counter saturates and never wraps.

## Timing
- Latency: the debiased bit is registered on the edge that samples the second bit of its pair.
- Best case, a word is visible WORD_WIDTH×2 enabled cycles after the first sample. `word_valid` rises the cycle after the edge that accepts the final bit.
- Simultaneous events in one edge:
  - word completion plus an accepted transfer: the new word replaces the old one and `word_valid` stays 1;
  - health trip plus word completion: the health trip wins, so no word is produced.
- `reset` mid-transfer drops any word. `reset` takes priority over every other input.
- No combinational path from `word_ready` to `word_valid` or `word_data`.

## Structure
- Shared package `trng_pkg`:
  - default `WORD_WIDTH` and `REP_LIMIT` constants;
  - the pair-phase encoding.
  - Values agree with `params.vh` usage.
- Sub-module `vn_debias`:
  - ports: `clock`, `reset`, sample strobe, bit in, phase clear;
  - outputs: `db_valid`, `db_bit`.
- Packing, output slot and health test live in `trng_postproc`.

## Test plan
- **Basic packing.** WORD_WIDTH=8, enable=1, `word_ready`=1, raw stream repeating 1,0 for 16 cycles → one word 8'hFF, `word_valid` high for 1 cycle. Stream 0,1 ×8 → word 8'h00. Alternating pairs 10,01 ×4 → word 8'hAA.
- **Discarded pairs.** Pairs 00,11 interleaved with 10 → only the 10 pairs contribute. Word count matches the reference model; no `overflow`.
- **Backpressure.** `word_ready`=0 with a 10-stream continuing:
  - word 1 is held stable;
  - word 2 fills the shift register;
  - the next debiased bit sets `overflow`.
  - Raising `word_ready` → word 1 transfers, then word 2 appears the next cycle.
- **Health trip.** REP_LIMIT=32, `raw_bit` stuck at 1:
  - `health_fail` rises on the 32nd sample;
  - `word_valid` is forced to 0;
  - no words follow, even after an alternating stream resumes, until `reset`.
- **Enable gap.** Drop `enable` after the first bit of a pair → the half pair is discarded and the repetition count restarts. Verify with 31 ones, enable low 1 cycle, 31 ones → no `health_fail`.
- **Reset mid-operation.** Assert `reset` while `word_valid`=1, `overflow`=1 and `health_fail`=1 → all outputs 0 the next cycle; normal packing resumes afterwards.

Source files
------------

// File: rtl/trng_pkg.sv
// trng_pkg: shared constants and types for the TRNG post-processing slice.
//   WORD_WIDTH_DEF : default debiased bits per output word
//   REP_LIMIT_DEF  : default repetition-count trip threshold
//   pair_phase_e   : von Neumann pair phase encoding
package trng_pkg;

  localparam int WORD_WIDTH_DEF = 8;
  localparam int REP_LIMIT_DEF  = 32;

  typedef enum logic {
    PHASE_FIRST  = 1'b0,
    PHASE_SECOND = 1'b1
  } pair_phase_e;

endpackage

// File: rtl/trng_postproc_if.sv
// trng_postproc_if: word delivery handshake.
//   word_data  : packed random word (source -> sink)
//   word_valid : word_data holds an unconsumed word (source -> sink)
//   word_ready : sink accepts the word this cycle (sink -> source)
interface trng_postproc_if #(
  parameter int WORD_WIDTH = trng_pkg::WORD_WIDTH_DEF
) ();

  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/vn_debias.sv
// vn_debias: von Neumann extractor over pairs of raw samples.
//   clock, reset : clock and synchronous active-high reset
//   sample_en    : take bit_in as the next sample this edge
//   bit_in       : raw sample
//   phase_clr    : drop any half pair, next sample starts a new pair
//   db_valid     : registered, high for one cycle when a pair yields a bit
//   db_bit       : the debiased bit (first sample of a 10/01 pair)
//
// state        | meaning
// PHASE_FIRST  | waiting for the first sample of a pair
// PHASE_SECOND | first sample held, next sample closes the pair
module vn_debias
  import trng_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic sample_en,
  input  logic bit_in,
  input  logic phase_clr,
  output logic db_valid,
  output logic db_bit
);

  pair_phase_e phase_q, phase_d;
  logic        first_q, first_d;
  logic        db_valid_q, db_valid_d;
  logic        db_bit_q, db_bit_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q    <= PHASE_FIRST;
      first_q    <= 1'b0;
      db_valid_q <= 1'b0;
      db_bit_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      first_q    <= first_d;
      db_valid_q <= db_valid_d;
      db_bit_q   <= db_bit_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    first_d    = first_q;
    db_valid_d = 1'b0;
    db_bit_d   = db_bit_q;
    if (phase_clr) begin
      phase_d = PHASE_FIRST;
    end else if (sample_en) begin
      case (phase_q)
        PHASE_FIRST: begin
          first_d = bit_in;
          phase_d = PHASE_SECOND;
        end
        PHASE_SECOND: begin
          phase_d = PHASE_FIRST;
          // 10 -> 1, 01 -> 0: the bit equals the first sample
          if (first_q != bit_in) begin
            db_valid_d = 1'b1;
            db_bit_d   = first_q;
          end
        end
        default: phase_d = PHASE_FIRST;
      endcase
    end
  end

  assign db_valid = db_valid_q;
  assign db_bit   = db_bit_q;

endmodule

// File: rtl/trng_postproc.sv
// trng_postproc: debias, pack and health-test the raw ring-oscillator stream.
//   clock, reset : clock and synchronous active-high reset
//   enable       : sampling enable
//   raw_bit      : combiner output, registered in the clock domain
//   bus          : word_data / word_valid / word_ready handshake (master side)
//   health_fail  : sticky repetition-count failure, blocks all output
//   overflow     : sticky, a debiased bit was dropped while a word was held
module trng_postproc
  import trng_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                raw_bit,
  trng_postproc_if.master     bus,
  output logic                health_fail,
  output logic                overflow
);

  localparam int CW = $clog2(REP_LIMIT + 1);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] REP_MAX   = CW'(REP_LIMIT);
  localparam logic [BW-1:0] BITS_FULL = BW'(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  hf_q, hf_d;
  logic                  ovf_q, ovf_d;
  logic [CW-1:0]         rep_cnt_q, rep_cnt_d;
  logic                  last_q, last_d;
  logic                  last_vld_q, last_vld_d;

  logic                  sample_en;
  logic                  db_valid;
  logic                  db_bit;
  logic                  db_in;
  logic                  slot_free;
  logic                  trip;
  logic [WORD_WIDTH-1:0] shift_n;
  logic [BW-1:0]         bit_cnt_n;

  assign sample_en = enable & ~hf_q;

  vn_debias u_vn_debias (
    .clock     (clock),
    .reset     (reset),
    .sample_en (sample_en),
    .bit_in    (raw_bit),
    .phase_clr (~enable | hf_q),
    .db_valid  (db_valid),
    .db_bit    (db_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      hf_q       <= 1'b0;
      ovf_q      <= 1'b0;
      rep_cnt_q  <= '0;
      last_q     <= 1'b0;
      last_vld_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      hf_q       <= hf_d;
      ovf_q      <= ovf_d;
      rep_cnt_q  <= rep_cnt_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  // Repetition-count health test on the raw stream.
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    trip       = 1'b0;
    if (!enable) begin
      rep_cnt_d  = '0;
      last_vld_d = 1'b0;
    end else if (!hf_q) begin
      last_d     = raw_bit;
      last_vld_d = 1'b1;
      if (last_vld_q && (raw_bit == last_q)) begin
        if (rep_cnt_q != REP_MAX) rep_cnt_d = rep_cnt_q + CW'(1);
      end else begin
        rep_cnt_d = CW'(1);
      end
      trip = (rep_cnt_d == REP_MAX);
    end
  end

  assign shift_n   = {shift_q[WORD_WIDTH-2:0], db_bit};
  assign bit_cnt_n = bit_cnt_q + BW'(1);

  // Packing and single-entry output slot.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    db_in     = db_valid & ~hf_q;
    slot_free = ~valid_q | bus.word_ready;

    if (valid_q && bus.word_ready) valid_d = 1'b0;

    if (bit_cnt_q == BITS_FULL) begin
      if (slot_free) begin
        // held word leaves; a bit arriving now starts the next word
        data_d    = shift_q;
        valid_d   = 1'b1;
        shift_d   = {{(WORD_WIDTH-1){1'b0}}, db_bit};
        bit_cnt_d = db_in ? BW'(1) : '0;
      end else if (db_in) begin
        ovf_d = 1'b1;
      end
    end else if (db_in) begin
      if ((bit_cnt_n == BITS_FULL) && slot_free) begin
        data_d    = shift_n;
        valid_d   = 1'b1;
        bit_cnt_d = '0;
      end else begin
        shift_d   = shift_n;
        bit_cnt_d = bit_cnt_n;
      end
    end

    // a trip beats any word completion on the same edge
    if (trip || hf_q) begin
      valid_d   = 1'b0;
      shift_d   = '0;
      bit_cnt_d = '0;
    end
    hf_d = hf_q | trip;
  end

  assign bus.word_data  = data_q;
  assign bus.word_valid = valid_q;
  assign health_fail    = hf_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_trng_postproc.sv
module tb_trng_postproc;
  import trng_pkg::*;

  localparam int W   = 8;
  localparam int LIM = 32;

  logic clock = 1'b0;
  logic reset, enable, raw_bit;
  logic health_fail, overflow;

  trng_postproc_if #(.WORD_WIDTH(W)) bus ();

  trng_postproc #(.WORD_WIDTH(W), .REP_LIMIT(LIM)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .raw_bit     (raw_bit),
    .bus         (bus),
    .health_fail (health_fail),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (behavioural) ----------------
  bit m_have = 0, m_first = 0, m_pend = 0, m_pend_bit = 0;
  int m_bits = 0, m_acc = 0;
  bit m_slot_valid = 0, m_ovf = 0, m_hf = 0;
  int m_run = 0, m_last = -1;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int valid_cycles = 0;

  task automatic model_load();
    exp_q.push_back(W'(m_acc));
    m_slot_valid = 1;
    m_bits = 0;
    m_acc = 0;
  endtask

  task automatic model_edge(input bit r, input bit e, input bit b, input bit rd);
    bit newbit, nb_val, slot_free, trip;
    if (r) begin
      m_have = 0; m_pend = 0; m_bits = 0; m_acc = 0;
      m_slot_valid = 0; m_ovf = 0; m_hf = 0; m_run = 0; m_last = -1;
      exp_q.delete();
      return;
    end
    newbit    = m_pend && !m_hf;
    nb_val    = m_pend_bit;
    slot_free = !m_slot_valid || rd;
    trip      = 0;
    if (!e) begin
      m_run = 0; m_last = -1;
    end else if (!m_hf) begin
      if (m_last == int'(b)) m_run = (m_run < LIM) ? m_run + 1 : LIM;
      else m_run = 1;
      m_last = int'(b);
      trip = (m_run == LIM);
    end
    m_pend = 0;
    if (!e || m_hf) m_have = 0;
    else if (!m_have) begin m_first = b; m_have = 1; end
    else begin
      m_have = 0;
      if (m_first != b) begin m_pend = 1; m_pend_bit = m_first; end
    end
    if (m_slot_valid && rd) m_slot_valid = 0;
    if (m_bits == W) begin
      if (slot_free) begin
        model_load();
        if (newbit) begin m_acc = int'(nb_val); m_bits = 1; end
      end else if (newbit) m_ovf = 1;
    end else if (newbit) begin
      m_acc = m_acc * 2 + int'(nb_val);
      m_bits++;
      if (m_bits == W && slot_free) model_load();
    end
    if (trip || m_hf) begin
      m_slot_valid = 0; m_bits = 0; m_acc = 0;
      exp_q.delete();
    end
    if (trip) m_hf = 1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] prev_data = '0;
  bit prev_hold = 0;

  always @(negedge clock) begin
    chk("word_valid", 32'(bus.word_valid), 32'(m_slot_valid));
    chk("health_fail", 32'(health_fail), 32'(m_hf));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (bus.word_valid === 1'b1) begin
      valid_cycles++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL word_data: got 0x%0h, expected no word (t=%0t)", bus.word_data, $time);
      end else begin
        chk("word_data", 32'(bus.word_data), 32'(exp_q[0]));
      end
      if (prev_hold) chk("word_data_stable", 32'(bus.word_data), 32'(prev_data));
      if (bus.word_ready === 1'b1) begin
        got_q.push_back(bus.word_data);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    prev_hold = (bus.word_valid === 1'b1) && (bus.word_ready !== 1'b1);
    prev_data = bus.word_data;
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit e, input bit b, input bit rd);
    reset = r; enable = e; raw_bit = b; bus.word_ready = rd;
    @(posedge clock);
    model_edge(r, e, b, rd);
    #1;
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(0, 0, 0, rd);
  endtask

  task automatic pairs(input bit a, input bit b, input int n, input bit rd);
    for (int i = 0; i < n; i++) begin
      step(0, 1, a, rd);
      step(0, 1, b, rd);
    end
  endtask

  task automatic ones(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(0, 1, 1, rd);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic clear_log();
    got_q.delete();
    valid_cycles = 0;
  endtask

  task automatic word_at(input string name, input int idx, input logic [W-1:0] exp);
    if (idx >= got_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: got no word at index %0d, expected 0x%0h", name, idx, exp);
    end else begin
      chk(name, 32'(got_q[idx]), 32'(exp));
    end
  endtask

  task automatic outputs_zero(input string name);
    chk({name, "_valid"}, 32'(bus.word_valid), 0);
    chk({name, "_data"}, 32'(bus.word_data), 0);
    chk({name, "_health"}, 32'(health_fail), 0);
    chk({name, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    do_reset();
    outputs_zero("reset");

    // basic packing
    clear_log();
    pairs(1, 0, 8, 1); idle(3, 1);
    chk("ff_count", 32'(got_q.size()), 1);
    word_at("ff_word", 0, 8'hFF);
    chk("ff_valid_cycles", 32'(valid_cycles), 1);
    clear_log();
    pairs(0, 1, 8, 1); idle(3, 1);
    chk("00_count", 32'(got_q.size()), 1);
    word_at("00_word", 0, 8'h00);
    clear_log();
    for (int i = 0; i < 4; i++) begin pairs(1, 0, 1, 1); pairs(0, 1, 1, 1); end
    idle(3, 1);
    word_at("aa_word", 0, 8'hAA);

    // discarded pairs
    clear_log();
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0: pairs(0, 0, 1, 1);
        1: pairs(1, 1, 1, 1);
        default: pairs(1, 0, 1, 1);
      endcase
    end
    idle(3, 1);
    chk("discard_count", 32'(got_q.size()), 1);
    word_at("discard_word", 0, 8'hFF);
    chk("discard_ovf", 32'(overflow), 0);

    // backpressure
    clear_log();
    pairs(1, 0, 8, 0);
    pairs(0, 1, 8, 0);
    pairs(1, 0, 1, 0);
    idle(1, 0);
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_held_valid", 32'(bus.word_valid), 1);
    chk("bp_held_data", 32'(bus.word_data), 32'h00FF);
    idle(3, 1);
    chk("bp_count", 32'(got_q.size()), 2);
    word_at("bp_word1", 0, 8'hFF);
    word_at("bp_word2", 1, 8'h00);

    // reset mid-operation with valid and overflow set
    do_reset();
    pairs(1, 0, 8, 0); pairs(1, 0, 8, 0); pairs(1, 0, 1, 0); idle(1, 0);
    chk("rst1_pre_ovf", 32'(overflow), 1);
    step(1, 0, 0, 1);
    outputs_zero("rst1");

    // health trip with a word pending
    do_reset();
    pairs(1, 0, 8, 0);
    ones(31, 0);
    chk("trip31_health", 32'(health_fail), 0);
    chk("trip31_valid", 32'(bus.word_valid), 1);
    ones(1, 0);
    chk("trip32_health", 32'(health_fail), 1);
    chk("trip32_valid", 32'(bus.word_valid), 0);
    clear_log();
    pairs(1, 0, 16, 1); idle(3, 1);
    chk("trip_no_words", 32'(got_q.size()), 0);
    chk("trip_sticky", 32'(health_fail), 1);
    // reset with health_fail and overflow both set
    pairs(1, 0, 1, 1);
    step(1, 0, 0, 0);
    outputs_zero("rst2");
    clear_log();
    pairs(1, 0, 8, 1); idle(3, 1);
    word_at("resume_word", 0, 8'hFF);

    // enable gap
    do_reset();
    ones(31, 1); step(0, 0, 1, 1); ones(31, 1); idle(2, 1);
    chk("gap_health", 32'(health_fail), 0);
    clear_log();
    step(0, 1, 1, 1); step(0, 0, 0, 1);
    pairs(0, 1, 8, 1); idle(3, 1);
    chk("gap_count", 32'(got_q.size()), 1);
    word_at("gap_word", 0, 8'h00);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      bit r, e, b, rd;
      r  = (c % 500 == 0) || ($urandom_range(0, 999) == 0);
      e  = ($urandom_range(0, 9) != 0);
      if ((c / 500) % 3 == 2) b = ($urandom_range(0, 19) != 0);
      else b = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 2) != 0);
      step(r, e, b, rd);
    end
    idle(4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
